// File: rtl/tt_penguronik_divider_if.sv
// Tiny Tapeout tile bus for the divider: data in, control/status pins, result out.
// The host side is the master; the divider tile is the slave.
interface tt_penguronik_divider_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    modport master (output ena, ui_in, uio_in, input uio_out, uio_oe, uo_out);
    modport slave  (input ena, ui_in, uio_in, output uio_out, uio_oe, uo_out);
endinterface

// File: rtl/tt_penguronik_divider.sv
// Sequential 8-bit unsigned restoring divider tile: one quotient bit per clock,
// with quotient/remainder on uo_out and busy/done/dz status on uio_out.
module tt_penguronik_divider (
    input logic                    clk,
    input logic                    rst,
    tt_penguronik_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] a, a_nxt;
    logic [7:0] b, b_nxt;
    logic [7:0] q, q_nxt;
    logic [8:0] r, r_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       dz, dz_nxt;

    logic       load_a, start, sel;
    logic [8:0] shifted;
    logic [9:0] diff;
    logic       busy, done;

    assign load_a = bus.uio_in[0];
    assign start  = bus.uio_in[1];
    assign sel    = bus.uio_in[5];

    // Extra headroom bit makes diff[9] a clean borrow flag for the trial subtract.
    assign shifted = {r[7:0], q[7]};
    assign diff    = {1'b0, shifted} - {2'b00, b};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            q     <= '0;
            r     <= '0;
            cnt   <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            q     <= q_nxt;
            r     <= r_nxt;
            cnt   <= cnt_nxt;
            dz    <= dz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        q_nxt     = q;
        r_nxt     = r;
        cnt_nxt   = cnt;
        dz_nxt    = dz;
        case (state)
            IDLE, DONE: begin
                // start takes priority over load_a; ui_in is then the divisor.
                if (start) begin
                    if (bus.ui_in != 8'd0) begin
                        b_nxt     = bus.ui_in;
                        q_nxt     = a;
                        r_nxt     = '0;
                        cnt_nxt   = '0;
                        dz_nxt    = 1'b0;
                        state_nxt = DIV;
                    end else begin
                        q_nxt     = '1;
                        r_nxt     = {1'b0, a};
                        dz_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (load_a) begin
                    a_nxt = bus.ui_in;
                end
            end
            DIV: begin
                if (!diff[9]) begin
                    r_nxt = diff[8:0];
                    q_nxt = {q[6:0], 1'b1};
                end else begin
                    r_nxt = shifted;
                    q_nxt = {q[6:0], 1'b0};
                end
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd7) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state == DIV);
    assign done        = (state == DONE);
    assign bus.uio_oe  = 8'b0001_1100;
    assign bus.uio_out = {3'b000, dz & done, done, busy, 2'b00};
    assign bus.uo_out  = done ? (sel ? r[7:0] : q) : 8'd0;

    logic unused;
    assign unused = &{1'b0, bus.ena, bus.uio_in[7:6], bus.uio_in[4:2], r[8]};
endmodule
